reg64_unloader: RTL
===================

Name: reg64_unloader

Overview:
Reader-side companion to the 64-bit write-enabled register. It captures a 64-bit word from a register output in one cycle and streams it out in CHUNK-bit beats over a valid/ready interface. It sits between the register bank and narrow consumers such as a debug/scan port, a narrow bus or a UART bridge. It holds the word internally, so the source register may be rewritten as soon as the capture handshake completes.

Parameters:
CHUNK, 8, beat width in bits; legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64). BEATS = 64/CHUNK.
MSB_FIRST, 0, 0 = least-significant chunk sent first; 1 = most-significant chunk sent first.

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a word to capture
in_ready  output  1  unloader can capture a word
in_data  input  64  word to unload, typically a register output
out_valid  output  1  out_data holds a valid beat
out_ready  input  1  consumer accepts the beat
out_data  output  CHUNK  current beat
out_last  output  1  current beat is the final beat of the word
busy  output  1  a word is being unloaded
sent_count  output  16  number of words fully delivered; wraps

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clock):
  - state = IDLE; shift register = 0; beat counter = 0; sent_count = 0.
  - Outputs: out_valid = 0, out_last = 0, out_data = 0, busy = 0, in_ready = 1.
- Outputs are functions of registered state only: in_ready = (state == IDLE), busy = (state == SEND), out_valid = busy. There is no combinational path from any input to any output.
- IDLE state:
  - When in_valid & in_ready at a rising edge: capture in_data into the shift register, clear the beat counter, enter SEND.
  - The first beat is valid in the following cycle, so capture-to-first-beat latency is 1 cycle.
- SEND state:
  - out_data = head chunk of the shift register: bits [CHUNK-1:0] when MSB_FIRST=0, bits [63:64-CHUNK] when MSB_FIRST=1.
  - out_last = (beat counter == BEATS-1).
  - On out_valid & out_ready: shift the register by CHUNK toward the head, fill with zeros, increment the beat counter.
  - On acceptance of the last beat: return to IDLE and increment sent_count (mod 2^16; 0xFFFF wraps to 0x0000).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and the beat counter hold stable.
- in_data and in_valid are ignored in SEND; no word is queued. Throughput with out_ready held high is one word per BEATS+1 cycles (one idle bubble per word).
- CHUNK=64: a single beat with out_last=1; the shift is a no-op.
- Reset during SEND aborts the word: partial data is discarded and sent_count is cleared.
- The beat counter is ceil(log2(BEATS)) bits wide, minimum 1 bit, and never exceeds BEATS-1.

Test Plan:
- Basic transfer: reset, then CHUNK=8, MSB_FIRST=0, in_data=64'h0123456789ABCDEF, out_ready=1 -> beats EF,CD,AB,89,67,45,23,01 on 8 consecutive cycles starting 1 cycle after capture; out_last=1 only on 01; sent_count=1; in_ready=1 the cycle after the last beat.
- Order reversal: same word with MSB_FIRST=1 -> beats 01,23,45,67,89,AB,CD,EF; out_last on EF.
- Backpressure: drop out_ready for 3 cycles at beat 3 -> out_data=89 held stable for those 3 cycles; no beat lost or duplicated; total 11 cycles of out_valid.
- Ignored input: pulse in_valid with in_data=64'hFFFF_FFFF_FFFF_FFFF during SEND -> in_ready=0 throughout; beat stream unchanged; sent_count increments by 1 only.
- Mid-word reset: assert reset asynchronously after beat 4 -> out_valid, busy and sent_count go to 0 immediately; a fresh word 64'h1 afterwards yields 01,00,00,00,00,00,00,00.
- Counter wrap and width: force 65536 words (or preload via bench) -> sent_count wraps 0xFFFF -> 0x0000. With CHUNK=64, in_data=64'hDEADBEEF00C0FFEE -> single beat, out_last=1.

Source files
------------

// File: rtl/reg64_unloader.sv
// Captures a 64-bit register word in one handshake and streams it out as
// CHUNK-bit beats over valid/ready; the word is held internally while sending.
module reg64_unloader #(
    parameter int CHUNK     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHUNK-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      sent_count
);
    localparam int BEATS = 64 / CHUNK;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [63:0]      shifted;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [15:0]      sent_q, sent_d;
    logic [CHUNK-1:0] head;
    logic             last_beat;

    // The head chunk sits at whichever end leaves first; shifting moves the next chunk into it.
    generate
        if (CHUNK == 64) begin : g_single
            assign shifted = shift_q;
            assign head    = shift_q;
        end else if (MSB_FIRST) begin : g_msb
            assign shifted = {shift_q[63-CHUNK:0], {CHUNK{1'b0}}};
            assign head    = shift_q[63:64-CHUNK];
        end else begin : g_lsb
            assign shifted = {{CHUNK{1'b0}}, shift_q[63:CHUNK]};
            assign head    = shift_q[CHUNK-1:0];
        end
    endgenerate

    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            beat_q  <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
            sent_q  <= sent_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        sent_d  = sent_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SEND;
                    shift_d = in_data;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    shift_d = shifted;
                    if (last_beat) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        sent_d  = sent_q + 16'd1;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs depend on registered state only; beat data is zeroed while idle.
    always_comb begin
        in_ready   = (state_q == IDLE);
        busy       = (state_q == SEND);
        out_valid  = busy;
        out_last   = busy & last_beat;
        out_data   = busy ? head : '0;
        sent_count = sent_q;
    end

endmodule
